// File: rtl/arp_pkg.sv
// arp_pkg: arpeggiator mode encodings, note period constants and the default step table.
package arp_pkg;

  typedef enum logic [1:0] {
    ARP_UP       = 2'd0,
    ARP_DOWN     = 2'd1,
    ARP_PINGPONG = 2'd2,
    ARP_HOLD     = 2'd3
  } arp_mode_e;

  // Periods in 50 MHz clocks
  localparam int unsigned C3 = 382233;
  localparam int unsigned D3 = 340529;
  localparam int unsigned F3 = 286352;
  localparam int unsigned A3 = 227272;
  localparam int unsigned C4 = 191116;

  function automatic int unsigned default_period(input int i);
    case (i)
      0:       return C4;
      1:       return D3;
      2:       return F3;
      3:       return A3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/arp_tone_gen.sv
// arp_tone_gen: square wave from a latched period P; cnt runs 0..P so one cycle is P+1 clocks.
module arp_tone_gen #(
  parameter int PERIOD_W = 20
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                LOAD,
  input  logic [PERIOD_W-1:0] PERIOD_IN,
  output logic                SPEAKER
);

  logic [PERIOD_W-1:0] cnt, p, cnt_nxt, p_nxt;

  // P only changes on a wrap or a step change, so a table write never cuts a half-period short
  always_comb begin
    cnt_nxt = cnt + PERIOD_W'(1);
    p_nxt   = p;
    if (LOAD || cnt >= p) begin
      cnt_nxt = '0;
      p_nxt   = PERIOD_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      p       <= '0;
      SPEAKER <= 1'b0;
    end else if (!EN) begin
      SPEAKER <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      p       <= p_nxt;
      SPEAKER <= (p_nxt != '0) && (cnt_nxt > (p_nxt >> 1));
    end
  end

endmodule

// File: rtl/arp_sequencer.sv
// arp_sequencer: table-driven arpeggiator stepping through STEPS note periods on SPEAKER.
// Define ARP_GATE_EN to add the GATE_OFF staccato input.
module arp_sequencer
  import arp_pkg::*;
#(
  parameter int  STEPS    = 4,
  parameter int  PERIOD_W = 20,
  parameter int  DUR_W    = 26,
  localparam int IDX_W    = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [1:0]          MODE,
  input  logic [DUR_W-1:0]    STEP_DUR,
  input  logic                WR_EN,
  input  logic [IDX_W-1:0]    WR_ADDR,
  input  logic [PERIOD_W-1:0] WR_PERIOD,
`ifdef ARP_GATE_EN
  input  logic [DUR_W-1:0]    GATE_OFF,
`endif
  output logic                SPEAKER,
  output logic [IDX_W-1:0]    STEP_IDX,
  output logic                STEP_TICK,
  output logic [7:0]          LED_G
);

  localparam logic [IDX_W-1:0] LAST   = IDX_W'(STEPS - 1);
  localparam logic [IDX_W:0]   NSTEPS = (IDX_W + 1)'(STEPS);

  logic [PERIOD_W-1:0] tbl [STEPS];
  logic [DUR_W-1:0]    dcnt, dcnt_nxt, sd_eff;
  logic [IDX_W-1:0]    idx_step, idx_nxt;
  logic                dir, dir_step, go_up, adv, spk;

  assign sd_eff   = (STEP_DUR == '0) ? DUR_W'(1) : STEP_DUR;
  // >= so that shortening STEP_DUR below the running count ends the step at once
  assign adv      = EN && (dcnt >= sd_eff - DUR_W'(1));
  assign dcnt_nxt = adv ? '0 : (EN ? dcnt + DUR_W'(1) : dcnt);
  assign idx_nxt  = adv ? idx_step : STEP_IDX;

  // dir=1 means moving up; ping-pong decides at departure so end steps are not repeated
  always_comb begin
    idx_step = STEP_IDX;
    dir_step = dir;
    go_up    = 1'b0;
    if (STEPS > 1) begin
      case (arp_mode_e'(MODE))
        ARP_UP: begin
          idx_step = (STEP_IDX == LAST) ? '0 : STEP_IDX + IDX_W'(1);
          dir_step = 1'b1;
        end
        ARP_DOWN: begin
          idx_step = (STEP_IDX == '0) ? LAST : STEP_IDX - IDX_W'(1);
          dir_step = 1'b0;
        end
        ARP_PINGPONG: begin
          go_up    = dir ? (STEP_IDX != LAST) : (STEP_IDX == '0);
          idx_step = go_up ? STEP_IDX + IDX_W'(1) : STEP_IDX - IDX_W'(1);
          dir_step = go_up;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      STEP_IDX  <= '0;
      STEP_TICK <= 1'b0;
      dir       <= 1'b1;
      dcnt      <= '0;
      for (int i = 0; i < STEPS; i++) tbl[i] <= PERIOD_W'(default_period(i));
    end else begin
      dcnt      <= dcnt_nxt;
      STEP_TICK <= adv;
      if (adv) begin
        STEP_IDX <= idx_step;
        dir      <= dir_step;
      end
      if (WR_EN && ({1'b0, WR_ADDR} < NSTEPS)) tbl[WR_ADDR] <= WR_PERIOD;
    end
  end

  // The new step reads the table before this cycle's write lands
  arp_tone_gen #(.PERIOD_W(PERIOD_W)) u_tone (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .LOAD      (adv),
    .PERIOD_IN (tbl[idx_nxt]),
    .SPEAKER   (spk)
  );

`ifdef ARP_GATE_EN
  logic gate_q;

  always_ff @(posedge CLK) begin
    if (RST) gate_q <= 1'b0;
    else     gate_q <= !((GATE_OFF >= sd_eff) || (dcnt_nxt >= sd_eff - GATE_OFF));
  end

  assign SPEAKER = spk & gate_q;
`else
  assign SPEAKER = spk;
`endif

  always_comb begin
    LED_G = '0;
    for (int i = 0; i < 8; i++)
      if (i < STEPS) LED_G[i] = (STEP_IDX == IDX_W'(i));
  end

endmodule
